// File: rtl/av_pkg.sv
// Shared widths, lane FSM state type and the slot x-position helper.
package av_pkg;

    localparam int TIME_W = 16;
    localparam int FRET_W = 5;
    localparam int X_W    = 11;
    localparam int Y_W    = 10;

    localparam logic [X_W-1:0] X_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_ENDED
    } lane_state_t;

    // Pixel column of a note: how far ahead of "now" it is, scaled to pixels.
    // Worked in TIME_W+1 bits so note_time + lead cannot wrap; a note already
    // past its lead window sits at column 0, a far-future note pins at X_MAX.
    function automatic logic [X_W-1:0] calc_x(
        input logic [TIME_W-1:0] note_time,
        input logic [TIME_W-1:0] now,
        input logic [TIME_W:0]   lead,
        input logic [TIME_W:0]   px_div
    );
        logic [TIME_W:0] ahead;
        logic [TIME_W:0] quot;
        ahead = {1'b0, note_time} + lead;
        quot  = '0;
        if (ahead > {1'b0, now}) begin
            quot = (ahead - {1'b0, now}) / px_div;
        end
        if (quot > (TIME_W+1)'(X_MAX)) begin
            return X_MAX;
        end
        return quot[X_W-1:0];
    endfunction

endpackage

// File: rtl/av_note_fifo.sv
// Circular note queue of {time, fret} with random read access at head+i,
// so the lane can look at the next few notes without popping them.
module av_note_fifo
    import av_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int VISIBLE = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [TIME_W-1:0]           push_time,
    input  logic [FRET_W-1:0]           push_fret,
    input  logic                        pop,
    output logic [$clog2(DEPTH):0]      count,
    output logic [VISIBLE*TIME_W-1:0]   rd_time,
    output logic [VISIBLE*FRET_W-1:0]   rd_fret
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [TIME_W-1:0] time_mem [DEPTH];
    logic [FRET_W-1:0] fret_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    // Note storage is written at the tail; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            time_mem[tail] <= push_time;
            fret_mem[tail] <= push_fret;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap for free since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    for (genvar i = 0; i < VISIBLE; i++) begin : g_rd
        logic [PTR_W-1:0] rd_ptr;
        assign rd_ptr = head + PTR_W'(i);
        assign rd_time[i*TIME_W +: TIME_W] = time_mem[rd_ptr];
        assign rd_fret[i*FRET_W +: FRET_W] = fret_mem[rd_ptr];
    end

endmodule

// File: rtl/av_note_lane.sv
// One note lane of the rhythm game: queues notes, scores strums against the
// head note, retires notes the player let slip by, and feeds the display.
module av_note_lane
    import av_pkg::*;
#(
    parameter logic [Y_W-1:0] Y_LOCATION = 10'd0,
    parameter int             DEPTH      = 32,
    parameter int             VISIBLE    = 5,
    parameter int             LEAD       = 50,
    parameter int             LATE       = 50,
    parameter int             HIT_WIN    = 10,
    parameter int             PX_DIV     = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TIME_W-1:0]         song_time,
    input  logic                      start,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [TIME_W-1:0]         load_time,
    input  logic [FRET_W-1:0]         load_fret,
    input  logic                      match_en,
    input  logic [FRET_W-1:0]         match_fret,
    input  logic [TIME_W-1:0]         match_time,
    output logic                      hit,
    output logic                      miss,
    output logic                      wrong,
    output logic                      done,
    output logic                      playing,
    output logic [X_W*VISIBLE-1:0]    slot_x,
    output logic [FRET_W*VISIBLE-1:0] slot_fret,
    output logic [VISIBLE-1:0]        slot_vld,
    output logic [Y_W-1:0]            y_loc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    lane_state_t               state;
    lane_state_t               state_d;
    logic                      end_play;
    logic [CNT_W-1:0]          count;
    logic [VISIBLE*TIME_W-1:0] rd_time;
    logic [VISIBLE*FRET_W-1:0] rd_fret;
    logic [TIME_W-1:0]         head_time;
    logic [FRET_W-1:0]         head_fret;
    logic                      load_accept;
    logic                      in_play;
    logic                      have_note;
    logic [TIME_W-1:0]         match_gap;
    logic [TIME_W-1:0]         late_gap;
    logic                      do_hit;
    logic                      do_retire;
    logic                      pop;

    assign y_loc       = Y_LOCATION;
    assign load_ready  = (count < CNT_W'(DEPTH));
    assign load_accept = load_valid && load_ready;
    assign in_play     = (state == ST_PLAY);
    assign playing     = in_play;
    assign have_note   = (count != '0);
    assign head_time   = rd_time[0 +: TIME_W];
    assign head_fret   = rd_fret[0 +: FRET_W];

    av_note_fifo #(
        .DEPTH   (DEPTH),
        .VISIBLE (VISIBLE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_accept),
        .push_time (load_time),
        .push_fret (load_fret),
        .pop       (pop),
        .count     (count),
        .rd_time   (rd_time),
        .rd_fret   (rd_fret)
    );

    // Strum scoring and late-note retirement; a hit wins the single pop slot.
    always_comb begin
        match_gap = (match_time >= head_time) ? (match_time - head_time)
                                              : (head_time - match_time);
        late_gap  = song_time - head_time;
        do_hit    = in_play && match_en && have_note &&
                    (match_fret == head_fret) &&
                    (match_gap <= TIME_W'(HIT_WIN));
        do_retire = in_play && have_note && (song_time > head_time) &&
                    (late_gap > TIME_W'(LATE));
        pop       = do_hit || do_retire;
    end

    // Lane state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Play ends once the queue has drained and nothing new is arriving.
    always_comb begin
        state_d  = state;
        end_play = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (!have_note && !load_accept) begin
                    state_d  = ST_ENDED;
                    end_play = 1'b1;
                end
            end
            ST_ENDED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Event pulses, one cycle after the decision that caused them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit   <= 1'b0;
            miss  <= 1'b0;
            wrong <= 1'b0;
            done  <= 1'b0;
        end else begin
            hit   <= do_hit;
            miss  <= do_retire && !do_hit;
            wrong <= in_play && match_en && !do_hit;
            done  <= end_play;
        end
    end

    for (genvar i = 0; i < VISIBLE; i++) begin : g_slot
        logic [TIME_W-1:0] s_time;
        logic [FRET_W-1:0] s_fret;
        logic              s_live;
        logic [X_W-1:0]    x_q;
        logic [FRET_W-1:0] fret_q;
        logic              vld_q;

        assign s_time = rd_time[i*TIME_W +: TIME_W];
        assign s_fret = rd_fret[i*FRET_W +: FRET_W];
        assign s_live = (CNT_W'(i) < count);

        // Display slot register; empty slots are forced to a blank note.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                x_q    <= '0;
                fret_q <= '0;
                vld_q  <= 1'b0;
            end else if (s_live) begin
                x_q    <= calc_x(s_time, song_time, (TIME_W+1)'(LEAD), (TIME_W+1)'(PX_DIV));
                fret_q <= s_fret;
                vld_q  <= 1'b1;
            end else begin
                x_q    <= '0;
                fret_q <= '0;
                vld_q  <= 1'b0;
            end
        end

        assign slot_x[(VISIBLE-1-i)*X_W +: X_W]          = x_q;
        assign slot_fret[(VISIBLE-1-i)*FRET_W +: FRET_W] = fret_q;
        assign slot_vld[i]                               = vld_q;
    end

endmodule

// File: tb/tb_av_note_lane.sv
// Directed bench for av_note_lane: a slot-position vector table plus
// hand-written sequences for full queue, retire, hit/wrong, priority, end and reset.
module tb_av_note_lane;
    import av_pkg::*;

    localparam int VIS = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    song_time;
    logic           start;
    logic           load_valid;
    logic           load_ready;
    logic [15:0]    load_time;
    logic [4:0]     load_fret;
    logic           match_en;
    logic [4:0]     match_fret;
    logic [15:0]    match_time;
    logic           hit, miss, wrong, done, playing;
    logic [11*VIS-1:0] slot_x;
    logic [5*VIS-1:0]  slot_fret;
    logic [VIS-1:0]    slot_vld;
    logic [9:0]        y_loc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] song;
        logic [10:0] x0;
        logic [10:0] x1;
        logic [10:0] x2;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    av_note_lane #(.Y_LOCATION(10'd37)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .song_time  (song_time),
        .start      (start),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_time  (load_time),
        .load_fret  (load_fret),
        .match_en   (match_en),
        .match_fret (match_fret),
        .match_time (match_time),
        .hit        (hit),
        .miss       (miss),
        .wrong      (wrong),
        .done       (done),
        .playing    (playing),
        .slot_x     (slot_x),
        .slot_fret  (slot_fret),
        .slot_vld   (slot_vld),
        .y_loc      (y_loc)
    );

    function automatic logic [10:0] xs(input int i);
        return slot_x[(VIS-1-i)*11 +: 11];
    endfunction

    function automatic logic [4:0] fs(input int i);
        return slot_fret[(VIS-1-i)*5 +: 5];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] st, input logic ld, input logic [15:0] lt,
                                 input logic [4:0] lf, input logic me, input logic [4:0] mf,
                                 input logic [15:0] mt);
        song_time  = st;
        load_valid = ld;
        load_time  = lt;
        load_fret  = lf;
        match_en   = me;
        match_fret = mf;
        match_time = mt;
        tick();
        load_valid = 1'b0;
        match_en   = 1'b0;
    endtask

    task automatic idle(input logic [15:0] st);
        applyStimulus(st, 1'b0, 16'd0, 5'd0, 1'b0, 5'd0, 16'd0);
    endtask

    task automatic loadNote(input logic [15:0] t, input logic [4:0] f);
        applyStimulus(song_time, 1'b1, t, f, 1'b0, 5'd0, 16'd0);
    endtask

    task automatic startPlay(input logic [15:0] st);
        song_time = st;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int done_cnt;
        rst_n = 1'b0; song_time = '0; start = 1'b0; load_valid = 1'b0;
        load_time = '0; load_fret = '0; match_en = 1'b0; match_fret = '0; match_time = '0;

        vecs[0] = '{16'd180,   11'd7,  11'd9,  11'd2047};
        vecs[1] = '{16'd250,   11'd0,  11'd2,  11'd2047};
        vecs[2] = '{16'd260,   11'd0,  11'd1,  11'd2047};
        vecs[3] = '{16'd0,     11'd25, 11'd27, 11'd2047};
        vecs[4] = '{16'd29000, 11'd0,  11'd0,  11'd105};
        vecs[5] = '{16'd29990, 11'd0,  11'd0,  11'd6};
        vecs[6] = '{16'd65535, 11'd0,  11'd0,  11'd0};
        vecs[7] = '{16'd230,   11'd2,  11'd4,  11'd2047};

        // Reset state
        tick();
        tick();
        checkOutput("rst_hit", hit, 0);
        checkOutput("rst_miss", miss, 0);
        checkOutput("rst_wrong", wrong, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_playing", playing, 0);
        checkOutput("rst_slot_vld", slot_vld, 0);
        checkOutput("rst_slot_x_zero", (slot_x == '0), 1);
        checkOutput("rst_slot_fret_zero", (slot_fret == '0), 1);
        checkOutput("y_loc", y_loc, 37);
        rst_n = 1'b1;
        tick();
        checkOutput("ready_after_rst", load_ready, 1);

        // Full queue in IDLE: 32 accepted, 33rd dropped
        for (int i = 0; i < 31; i++) loadNote(16'(i * 10), 5'(i));
        checkOutput("ready_at_31", load_ready, 1);
        loadNote(16'd310, 5'd31);
        checkOutput("ready_at_32", load_ready, 0);
        checkOutput("count_at_32", dut.u_fifo.count, 32);
        loadNote(16'd999, 5'd17);
        checkOutput("count_after_drop", dut.u_fifo.count, 32);
        checkOutput("ready_after_drop", load_ready, 0);
        checkOutput("full_vld", slot_vld, 5'h1F);
        checkOutput("full_fret0", fs(0), 0);
        checkOutput("full_x0", xs(0), 5);
        checkOutput("full_fret4", fs(4), 4);
        checkOutput("full_x4", xs(4), 9);

        // Slot display table
        resetDut();
        loadNote(16'd200, 5'd3);
        loadNote(16'd220, 5'd7);
        loadNote(16'd30000, 5'd9);
        for (int v = 0; v < 8; v++) begin
            idle(vecs[v].song);
            checkOutput($sformatf("vec%0d_x0", v), xs(0), vecs[v].x0);
            checkOutput($sformatf("vec%0d_x1", v), xs(1), vecs[v].x1);
            checkOutput($sformatf("vec%0d_x2", v), xs(2), vecs[v].x2);
            checkOutput($sformatf("vec%0d_x3", v), xs(3), 0);
            checkOutput($sformatf("vec%0d_vld", v), slot_vld, 5'b00111);
            checkOutput($sformatf("vec%0d_fret0", v), fs(0), 3);
            checkOutput($sformatf("vec%0d_fret2", v), fs(2), 9);
            checkOutput($sformatf("vec%0d_fret4", v), fs(4), 0);
        end

        // Retire boundary
        resetDut();
        loadNote(16'd200, 5'd1);
        loadNote(16'd1000, 5'd2);
        startPlay(16'd0);
        checkOutput("ret_playing", playing, 1);
        idle(16'd250);
        checkOutput("ret_no_miss_250", miss, 0);
        checkOutput("ret_count_250", dut.u_fifo.count, 2);
        idle(16'd251);
        checkOutput("ret_miss_251", miss, 1);
        checkOutput("ret_count_251", dut.u_fifo.count, 1);
        idle(16'd251);
        checkOutput("ret_miss_once", miss, 0);
        checkOutput("ret_new_head_fret", fs(0), 2);

        // Hit vs wrong, including window edges
        resetDut();
        loadNote(16'd300, 5'd2);
        loadNote(16'd400, 5'd1);
        loadNote(16'd5000, 5'd0);
        startPlay(16'd300);
        applyStimulus(16'd300, 1'b0, 16'd0, 5'd0, 1'b1, 5'd2, 16'd305);
        checkOutput("hit_pulse", hit, 1);
        checkOutput("hit_no_wrong", wrong, 0);
        checkOutput("hit_count", dut.u_fifo.count, 2);
        idle(16'd400);
        checkOutput("hit_one_cycle", hit, 0);
        applyStimulus(16'd400, 1'b0, 16'd0, 5'd0, 1'b1, 5'd4, 16'd400);
        checkOutput("wrong_fret", wrong, 1);
        checkOutput("wrong_fret_nohit", hit, 0);
        checkOutput("wrong_fret_count", dut.u_fifo.count, 2);
        applyStimulus(16'd400, 1'b0, 16'd0, 5'd0, 1'b1, 5'd1, 16'd411);
        checkOutput("wrong_late11", wrong, 1);
        checkOutput("wrong_late11_count", dut.u_fifo.count, 2);
        applyStimulus(16'd400, 1'b0, 16'd0, 5'd0, 1'b1, 5'd1, 16'd410);
        checkOutput("hit_late10", hit, 1);
        checkOutput("hit_late10_count", dut.u_fifo.count, 1);
        applyStimulus(16'd400, 1'b0, 16'd0, 5'd0, 1'b1, 5'd0, 16'd4989);
        checkOutput("wrong_early11", wrong, 1);
        applyStimulus(16'd400, 1'b0, 16'd0, 5'd0, 1'b1, 5'd0, 16'd4990);
        checkOutput("hit_early10", hit, 1);
        checkOutput("hit_early10_count", dut.u_fifo.count, 0);

        // Hit beats retire in the same cycle
        resetDut();
        loadNote(16'd100, 5'd3);
        loadNote(16'd120, 5'd3);
        loadNote(16'd9000, 5'd0);
        startPlay(16'd0);
        applyStimulus(16'd151, 1'b0, 16'd0, 5'd0, 1'b1, 5'd3, 16'd105);
        checkOutput("prio_hit", hit, 1);
        checkOutput("prio_no_miss", miss, 0);
        checkOutput("prio_count", dut.u_fifo.count, 2);
        idle(16'd151);
        checkOutput("prio_next_no_miss", miss, 0);
        idle(16'd171);
        checkOutput("prio_new_head_retire", miss, 1);
        checkOutput("prio_new_head_count", dut.u_fifo.count, 1);

        // Last note retires, done pulses once, back to IDLE
        resetDut();
        loadNote(16'd200, 5'd1);
        startPlay(16'd0);
        idle(16'd300);
        checkOutput("end_miss", miss, 1);
        checkOutput("end_count", dut.u_fifo.count, 0);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            idle(16'd300);
            if (done === 1'b1) done_cnt++;
        end
        checkOutput("end_done_once", done_cnt, 1);
        checkOutput("end_state_idle", (dut.state == ST_IDLE), 1);
        checkOutput("end_not_playing", playing, 0);

        // Reset in the middle of play
        resetDut();
        loadNote(16'd100, 5'd1);
        loadNote(16'd200, 5'd2);
        loadNote(16'd300, 5'd3);
        startPlay(16'd0);
        idle(16'd0);
        checkOutput("mid_vld_before", slot_vld, 5'b00111);
        checkOutput("mid_playing_before", playing, 1);
        rst_n = 1'b0;
        applyStimulus(16'd0, 1'b0, 16'd0, 5'd0, 1'b1, 5'd1, 16'd100);
        checkOutput("mid_rst_hit", hit, 0);
        checkOutput("mid_rst_wrong", wrong, 0);
        checkOutput("mid_rst_vld", slot_vld, 0);
        checkOutput("mid_rst_playing", playing, 0);
        idle(16'd1000);
        checkOutput("mid_rst_miss", miss, 0);
        checkOutput("mid_rst_done", done, 0);
        checkOutput("mid_rst_count", dut.u_fifo.count, 0);
        rst_n = 1'b1;
        idle(16'd1000);
        checkOutput("mid_after_ready", load_ready, 1);
        checkOutput("mid_after_vld", slot_vld, 0);
        checkOutput("mid_after_miss", miss, 0);
        checkOutput("mid_after_playing", playing, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/av_note_lane.md
AV_NOTE_LANE -- requirements
Module: av_note_lane

Interface
REQ-001 The block SHALL expose parameter Y_LOCATION, default 10'd0, giving the lane's screen row, passed through on y_loc.
REQ-002 The block SHALL expose parameter DEPTH, default 32 (power of two), giving note-queue entries.
REQ-003 The block SHALL expose parameter VISIBLE, default 5, giving the number of displayed note slots (VISIBLE <= DEPTH).
REQ-004 The block SHALL expose parameter LEAD, default 50, giving the time units a note is shown past its due time in the x calculation.
REQ-005 The block SHALL expose parameter LATE, default 50, giving the retire threshold in time units.
REQ-006 The block SHALL expose parameter HIT_WIN, default 10, giving the maximum |match_time - note_time| that counts as a hit.
REQ-007 The block SHALL expose parameter PX_DIV, default 10, giving time units per pixel.
REQ-008 The block SHALL have these ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- song_time  in  16  current song time.
- start  in  1  one-cycle pulse that begins play.
- load_valid  in  1  note write request.
- load_ready  out  1  queue can accept a note.
- load_time  in  16  note due time.
- load_fret  in  5  note fret value.
- match_en  in  1  player strum pulse.
- match_fret  in  5  strummed fret.
- match_time  in  16  strum timestamp.
- hit  out  1  one-cycle pulse: head note matched.
- miss  out  1  one-cycle pulse: head note retired unplayed.
- wrong  out  1  one-cycle pulse: strum matched nothing.
- done  out  1  one-cycle pulse: song ended.
- playing  out  1  high while in state PLAY.
- slot_x  out  11*VISIBLE  per-slot x; slot 0 in the MSBs.
- slot_fret  out  5*VISIBLE  per-slot fret; slot 0 in the MSBs.
- slot_vld  out  VISIBLE  per-slot valid; bit 0 = slot 0.
- y_loc  out  10  equals Y_LOCATION.

Function
REQ-009 The block SHALL hold notes in a circular FIFO (head, tail, count), time-ordered by load order. Loaded times are non-decreasing; the block does not check this.
REQ-010 The block SHALL set load_ready = (count < DEPTH), derived from registered count only, with no same-cycle bypass from a pop.
REQ-011 The block SHALL write a note when load_valid && load_ready, and SHALL silently drop load_valid while load_ready is low.
REQ-012 The block SHALL implement FSM states IDLE, PLAY and ENDED:
- IDLE -> PLAY on start.
- PLAY -> ENDED when count==0 at the end of a cycle with no load.
- ENDED -> IDLE the following cycle.
- start is ignored outside IDLE.
REQ-013 The block SHALL accept loads in every state, and SHALL pop, retire and match only in PLAY.
REQ-014 The block SHALL declare a hit in PLAY when match_en, count>0, match_fret==head fret and |match_time-head time| <= HIT_WIN. It SHALL pop the head and pulse hit in the next cycle.
REQ-015 The block SHALL pulse wrong, with no pop, when match_en in PLAY is not a hit. match_en outside PLAY SHALL be ignored.
REQ-016 The block SHALL retire the head in PLAY when count>0 and song_time > head_time and (song_time - head_time) > LATE. Retire SHALL be computed without underflow, SHALL pop, and SHALL pulse miss next cycle.
REQ-017 The block SHALL pop at most one note per cycle. Hit SHALL take priority over retire; when both qualify, only hit pulses and the retire is re-evaluated on the new head next cycle.
REQ-018 The block SHALL allow a simultaneous load and pop, giving count unchanged. When the FIFO is full, the load is still refused that cycle per REQ-010.
REQ-019 The block SHALL register slot outputs with one-cycle latency, for each slot i < VISIBLE:
- slot_vld[i] = (i < count).
- slot_fret = FIFO entry head+i (modulo DEPTH).
- slot_x = (time + LEAD - song_time)/PX_DIV, using 17-bit intermediate arithmetic, clamped to 0 when negative and saturated at 2047.
- Invalid slots SHALL output x=0 and fret=0.
REQ-020 The block SHALL pulse done for one cycle on the PLAY->ENDED transition.
REQ-021 The block SHALL drive playing = (state==PLAY).

Reset
REQ-022 While rst_n is low at a clk edge, the block SHALL clear head, tail and count, set state to IDLE, and zero hit, miss, wrong, done, playing, slot_x, slot_fret and slot_vld. load_ready SHALL read 1 on the cycle after reset.
REQ-023 Reset asserted mid-PLAY SHALL discard all queued notes with no pulse emitted. FIFO storage contents SHALL not require reset.

Structure
REQ-024 Shared package av_pkg SHALL hold TIME_W=16, FRET_W=5, X_W=11, Y_W=10 and the FSM state enum.
REQ-025 The storage SHALL be a sub-module av_note_fifo (DEPTH-entry {time,fret} FIFO with random read at head+i). The FSM, match/retire logic and slot pipeline SHALL be in av_note_lane.

Verification
REQ-026 The bench SHALL check reset and full: load 32 notes in IDLE -> load_ready=0 after the 32nd; the 33rd is dropped; count remains 32.
REQ-027 The bench SHALL check display: head at t=200, song_time=180 -> slot_x[0] = (200+50-180)/10 = 7 one cycle later, slot_vld[0]=1.
REQ-028 The bench SHALL check retire: head t=200 in PLAY, song_time steps 250 then 251 -> no miss at 250; miss pulses once at 251 and head advances.
REQ-029 The bench SHALL check hit vs. wrong: head t=300, fret 2; match_en with fret=2, time=305 -> hit and pop. Then match_en with fret=4 on head t=400 -> wrong, no pop.
REQ-030 The bench SHALL check priority: hit and retire qualify in the same cycle -> only hit, count drops by 1.
REQ-031 The bench SHALL check end and mid-play reset: the last note retires -> done pulses once, then state IDLE; rst_n low mid-PLAY -> all slot_vld=0 and no pulses.
